alu_multicycle: RTL and testbench

ALU_MULTICYCLE -- requirements
Module: alu_multicycle

---
 rtl/alu_pkg.sv | 34 +++
 rtl/alu_op_decode.sv | 36 +++
 rtl/alu_multicycle.sv | 156 +++++++++++++++
 tb/tb_alu_multicycle.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared ALU control codes, alu_op encodings and sequencer state encoding.
package alu_pkg;

  typedef enum logic [3:0] {
    CTRL_ADD  = 4'b0000,
    CTRL_SUB  = 4'b0001,
    CTRL_AND  = 4'b0010,
    CTRL_OR   = 4'b0011,
    CTRL_XOR  = 4'b0100,
    CTRL_SLT  = 4'b0101,
    CTRL_SLTU = 4'b0110,
    CTRL_SLL  = 4'b0111,
    CTRL_SRL  = 4'b1000,
    CTRL_SRA  = 4'b1001
  } alu_ctrl_e;

  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_FUNCT = 2'b10,
    ALUOP_RSVD  = 2'b11
  } alu_op_e;

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_SHIFT = 2'b01,
    S_DONE  = 2'b10
  } state_e;

  function automatic logic is_shift(alu_ctrl_e c);
    return (c == CTRL_SLL) || (c == CTRL_SRL) || (c == CTRL_SRA);
  endfunction

endpackage

// File: rtl/alu_op_decode.sv
// Combinational decode of alu_op / funct fields into a 4-bit ALU control code.
module alu_op_decode
  import alu_pkg::*;
(
  input  logic [1:0] alu_op_i,
  input  logic       op5_i,
  input  logic       funct7_5_i,
  input  logic [2:0] funct3_i,
  output logic [3:0] ctrl_o
);

  alu_ctrl_e ctrl;

  always_comb begin
    ctrl = CTRL_ADD;
    case (alu_op_e'(alu_op_i))
      ALUOP_SUB: ctrl = CTRL_SUB;
      ALUOP_FUNCT: begin
        case (funct3_i)
          3'b000:  ctrl = ({op5_i, funct7_5_i} == 2'b11) ? CTRL_SUB : CTRL_ADD;
          3'b001:  ctrl = CTRL_SLL;
          3'b010:  ctrl = CTRL_SLT;
          3'b011:  ctrl = CTRL_SLTU;
          3'b100:  ctrl = CTRL_XOR;
          3'b101:  ctrl = funct7_5_i ? CTRL_SRA : CTRL_SRL;
          3'b110:  ctrl = CTRL_OR;
          default: ctrl = CTRL_AND;
        endcase
      end
      default: ctrl = CTRL_ADD;
    endcase
  end

  assign ctrl_o = ctrl;

endmodule

// File: rtl/alu_multicycle.sv
// Handshaked ALU: single-cycle arithmetic/logic ops, iterative shifts retiring
// SHIFT_STEP bits per cycle, with a held response until out_ready.
module alu_multicycle
  import alu_pkg::*;
#(
  parameter int unsigned XLEN       = 32,
  parameter int unsigned SHIFT_STEP = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [1:0]      alu_op,
  input  logic            op5,
  input  logic            funct7_5,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] src_a,
  input  logic [XLEN-1:0] src_b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            zero,
  output logic            negative,
  output logic            carry,
  output logic            overflow,
  output logic [3:0]      alu_control
);

  localparam int unsigned SH_W  = $clog2(XLEN);
  // One extra bit so a step of XLEN is representable.
  localparam int unsigned CNT_W = SH_W + 1;

  state_e            state_q;
  alu_ctrl_e         ctrl_q;
  logic [XLEN-1:0]   result_q;
  logic              zero_q, negative_q, carry_q, overflow_q;
  logic [CNT_W-1:0]  cnt_q;

  logic [3:0]        dec_raw;
  alu_ctrl_e         dec_ctrl;
  logic              accept;
  logic [SH_W-1:0]   shamt;

  logic              is_sub;
  logic [XLEN-1:0]   b_eff;
  logic [XLEN:0]     sum;
  logic [XLEN-1:0]   alu_res;
  logic              alu_carry, alu_ovf;

  logic [CNT_W-1:0]  step;
  logic [CNT_W-1:0]  cnt_d;
  logic [XLEN-1:0]   shift_d;

  alu_op_decode u_decode (
    .alu_op_i   (alu_op),
    .op5_i      (op5),
    .funct7_5_i (funct7_5),
    .funct3_i   (funct3),
    .ctrl_o     (dec_raw)
  );

  assign dec_ctrl = alu_ctrl_e'(dec_raw);
  assign shamt    = src_b[SH_W-1:0];
  assign in_ready = !rst && ((state_q == S_IDLE) || ((state_q == S_DONE) && out_ready));
  assign accept   = in_valid && in_ready;

  // Single-cycle datapath; shift codes pass src_a through for the shamt==0 case.
  always_comb begin
    is_sub    = (dec_ctrl == CTRL_SUB);
    b_eff     = is_sub ? ~src_b : src_b;
    sum       = {1'b0, src_a} + {1'b0, b_eff} + (XLEN+1)'(is_sub);
    alu_res   = src_a;
    alu_carry = 1'b0;
    alu_ovf   = 1'b0;
    case (dec_ctrl)
      CTRL_ADD, CTRL_SUB: begin
        alu_res   = sum[XLEN-1:0];
        alu_carry = sum[XLEN];
        alu_ovf   = (src_a[XLEN-1] == b_eff[XLEN-1]) && (sum[XLEN-1] != src_a[XLEN-1]);
      end
      CTRL_AND:  alu_res = src_a & src_b;
      CTRL_OR:   alu_res = src_a | src_b;
      CTRL_XOR:  alu_res = src_a ^ src_b;
      CTRL_SLT:  alu_res = XLEN'($signed(src_a) < $signed(src_b));
      CTRL_SLTU: alu_res = XLEN'(src_a < src_b);
      default:   alu_res = src_a;
    endcase
  end

  // One shift iteration on the working value held in result_q.
  always_comb begin
    step  = (cnt_q > CNT_W'(SHIFT_STEP)) ? CNT_W'(SHIFT_STEP) : cnt_q;
    cnt_d = cnt_q - step;
    case (ctrl_q)
      CTRL_SLL: shift_d = result_q << step;
      CTRL_SRL: shift_d = result_q >> step;
      CTRL_SRA: shift_d = XLEN'($signed(result_q) >>> step);
      default:  shift_d = result_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      ctrl_q     <= CTRL_ADD;
      result_q   <= '0;
      zero_q     <= 1'b0;
      negative_q <= 1'b0;
      carry_q    <= 1'b0;
      overflow_q <= 1'b0;
      cnt_q      <= '0;
    end else if (accept) begin
      ctrl_q <= dec_ctrl;
      if (is_shift(dec_ctrl) && (shamt != '0)) begin
        state_q    <= S_SHIFT;
        result_q   <= src_a;
        cnt_q      <= CNT_W'(shamt);
        zero_q     <= 1'b0;
        negative_q <= 1'b0;
        carry_q    <= 1'b0;
        overflow_q <= 1'b0;
      end else begin
        state_q    <= S_DONE;
        result_q   <= alu_res;
        cnt_q      <= '0;
        zero_q     <= (alu_res == '0);
        negative_q <= alu_res[XLEN-1];
        carry_q    <= alu_carry;
        overflow_q <= alu_ovf;
      end
    end else begin
      case (state_q)
        S_SHIFT: begin
          result_q <= shift_d;
          cnt_q    <= cnt_d;
          if (cnt_d == '0) begin
            state_q    <= S_DONE;
            zero_q     <= (shift_d == '0);
            negative_q <= shift_d[XLEN-1];
          end
        end
        S_DONE: if (out_ready) state_q <= S_IDLE;
        default: ;
      endcase
    end
  end

  assign out_valid   = (state_q == S_DONE);
  assign result      = result_q;
  assign zero        = zero_q;
  assign negative    = negative_q;
  assign carry       = carry_q;
  assign overflow    = overflow_q;
  assign alu_control = ctrl_q;

endmodule

// File: tb/tb_alu_multicycle.sv
// Scoreboard bench for alu_multicycle (SHIFT_STEP 1 main instance, SHIFT_STEP 4 side instance).
module tb_alu_multicycle;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_valid4;
  logic        in_ready, in_ready4;
  logic [1:0]  alu_op;
  logic        op5, funct7_5;
  logic [2:0]  funct3;
  logic [31:0] src_a, src_b;
  logic        out_valid, out_valid4;
  logic        out_ready, out_ready4;
  logic [31:0] result, result4;
  logic        zero, negative, carry, overflow;
  logic        zero4, negative4, carry4, overflow4;
  logic [3:0]  alu_control, alu_control4;

  typedef struct packed {
    logic [31:0] res;
    logic [3:0]  flags;
    logic [3:0]  ctrl;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;

  alu_multicycle #(.XLEN(32), .SHIFT_STEP(1)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .alu_op(alu_op), .op5(op5), .funct7_5(funct7_5), .funct3(funct3),
    .src_a(src_a), .src_b(src_b), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .zero(zero), .negative(negative), .carry(carry),
    .overflow(overflow), .alu_control(alu_control)
  );

  alu_multicycle #(.XLEN(32), .SHIFT_STEP(4)) dut4 (
    .clk(clk), .rst(rst), .in_valid(in_valid4), .in_ready(in_ready4),
    .alu_op(alu_op), .op5(op5), .funct7_5(funct7_5), .funct3(funct3),
    .src_a(src_a), .src_b(src_b), .out_valid(out_valid4), .out_ready(out_ready4),
    .result(result4), .zero(zero4), .negative(negative4), .carry(carry4),
    .overflow(overflow4), .alu_control(alu_control4)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  // Reference model: decode plus wide arithmetic for carry/overflow.
  function automatic exp_t model(input logic [1:0] op, input logic o5, input logic f75,
                                 input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    exp_t        e;
    logic [3:0]  c;
    logic [31:0] r;
    logic        cy, ov;
    longint      s;
    int          sh;
    c  = 4'd0;
    cy = 1'b0;
    ov = 1'b0;
    sh = int'(b[4:0]);
    if (op == 2'b01) c = 4'd1;
    else if (op == 2'b10) begin
      case (f3)
        3'd0: c = (o5 && f75) ? 4'd1 : 4'd0;
        3'd1: c = 4'd7;
        3'd2: c = 4'd5;
        3'd3: c = 4'd6;
        3'd4: c = 4'd4;
        3'd5: c = f75 ? 4'd9 : 4'd8;
        3'd6: c = 4'd3;
        default: c = 4'd2;
      endcase
    end
    case (c)
      4'd0: begin
        r  = a + b;
        cy = (64'(a) + 64'(b)) > 64'hFFFF_FFFF;
        s  = longint'($signed(a)) + longint'($signed(b));
        ov = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
      4'd1: begin
        r  = a - b;
        cy = (a >= b);
        s  = longint'($signed(a)) - longint'($signed(b));
        ov = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
      4'd2: r = a & b;
      4'd3: r = a | b;
      4'd4: r = a ^ b;
      4'd5: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'd6: r = (a < b) ? 32'd1 : 32'd0;
      4'd7: r = a << sh;
      4'd8: r = a >> sh;
      default: r = $signed(a) >>> sh;
    endcase
    e.res   = r;
    e.flags = {(r == 32'd0), r[31], cy, ov};
    e.ctrl  = c;
    return e;
  endfunction

  task automatic compare_out(input string tag);
    exp_t e;
    check_eq({tag, "_sb_nonempty"}, 64'(sb_q.size() > 0), 64'd1);
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      check_eq({tag, "_result"}, result, e.res);
      check_eq({tag, "_flags"}, {zero, negative, carry, overflow}, e.flags);
      check_eq({tag, "_ctrl"}, alu_control, e.ctrl);
    end
  endtask

  task automatic run_op(input logic [1:0] op, input logic o5, input logic f75, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] b, input int exp_lat, input string tag);
    int lat;
    @(negedge clk);
    alu_op = op; op5 = o5; funct7_5 = f75; funct3 = f3; src_a = a; src_b = b;
    in_valid = 1'b1; out_ready = 1'b1;
    #1;
    check_eq({tag, "_in_ready"}, in_ready, 1'b1);
    @(posedge clk);
    sb_q.push_back(model(op, o5, f75, f3, a, b));
    #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    check_eq({tag, "_latency"}, 64'(lat), 64'(exp_lat));
    compare_out(tag);
    @(posedge clk); #1;
  endtask

  initial begin
    exp_t e;
    int   lat, lat4, seen;
    logic [1:0]  r_op;
    logic [2:0]  r_f3;
    logic        r_o5, r_f75;
    logic [31:0] r_a, r_b;

    rst = 1'b1; in_valid = 1'b0; in_valid4 = 1'b0; out_ready = 1'b1; out_ready4 = 1'b1;
    alu_op = 2'b00; op5 = 1'b0; funct7_5 = 1'b0; funct3 = 3'b000; src_a = '0; src_b = '0;
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_in_ready_low", in_ready, 1'b0);
    rst = 1'b0;
    #1;
    check_eq("rst_in_ready", in_ready, 1'b1);
    check_eq("rst_out_valid", out_valid, 1'b0);
    check_eq("rst_result", result, 32'd0);
    check_eq("rst_flags", {zero, negative, carry, overflow}, 4'b0000);
    check_eq("rst_ctrl", alu_control, 4'b0000);

    // Directed vectors with literal expectations on top of the model.
    run_op(2'b10, 1'b1, 1'b1, 3'b000, 32'd5, 32'd7, 1, "rsub");
    check_eq("rsub_lit", {result, negative, carry, alu_control}, {32'hFFFF_FFFE, 1'b1, 1'b0, 4'b0001});
    run_op(2'b00, 1'b0, 1'b0, 3'b000, 32'h7FFF_FFFF, 32'd1, 1, "add_ovf");
    check_eq("add_ovf_lit", {result, overflow, carry}, {32'h8000_0000, 1'b1, 1'b0});
    run_op(2'b00, 1'b0, 1'b0, 3'b000, 32'hFFFF_FFFF, 32'd1, 1, "add_wrap");
    check_eq("add_wrap_lit", {result, zero, carry}, {32'd0, 1'b1, 1'b1});
    run_op(2'b10, 1'b1, 1'b0, 3'b011, 32'd1, 32'hFFFF_FFFF, 1, "sltu");
    check_eq("sltu_lit", result, 32'd1);
    run_op(2'b10, 1'b1, 1'b0, 3'b010, 32'd1, 32'hFFFF_FFFF, 1, "slt");
    check_eq("slt_lit", result, 32'd0);
    run_op(2'b10, 1'b1, 1'b0, 3'b001, 32'h1234_5678, 32'h20, 1, "sll_sh0");
    check_eq("sll_sh0_lit", result, 32'h1234_5678);
    run_op(2'b10, 1'b1, 1'b1, 3'b101, 32'h8000_0000, 32'h24, 5, "sra4");
    check_eq("sra4_lit", result, 32'hF800_0000);

    // Same SRA on the 4-bit-per-cycle instance.
    @(negedge clk);
    alu_op = 2'b10; op5 = 1'b1; funct7_5 = 1'b1; funct3 = 3'b101;
    src_a = 32'h8000_0000; src_b = 32'h24; in_valid4 = 1'b1;
    #1;
    check_eq("s4_in_ready", in_ready4, 1'b1);
    @(posedge clk); #1;
    in_valid4 = 1'b0;
    lat4 = 1;
    while (!out_valid4 && lat4 < 200) begin
      @(posedge clk); #1;
      lat4++;
    end
    check_eq("s4_latency", 64'(lat4), 64'd2);
    check_eq("s4_out", {result4, zero4, negative4, carry4, overflow4, alu_control4},
             {32'hF800_0000, 4'b0100, 4'b1001});
    @(posedge clk); #1;

    // Backpressure then back-to-back accept.
    @(negedge clk);
    alu_op = 2'b00; op5 = 1'b0; funct7_5 = 1'b0; funct3 = 3'b000;
    src_a = 32'd3; src_b = 32'd4; in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk);
    sb_q.push_back(model(2'b00, 1'b0, 1'b0, 3'b000, 32'd3, 32'd4));
    #1;
    in_valid = 1'b0;
    check_eq("bp_out_valid", out_valid, 1'b1);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check_eq("bp_hold", {out_valid, in_ready, result, zero, negative, carry, overflow},
               {1'b1, 1'b0, 32'd7, 4'b0000});
    end
    @(negedge clk);
    alu_op = 2'b10; op5 = 1'b1; funct7_5 = 1'b0; funct3 = 3'b100;
    src_a = 32'h0000_F0F0; src_b = 32'h0000_FF00; in_valid = 1'b1; out_ready = 1'b1;
    #1;
    check_eq("b2b_in_ready", in_ready, 1'b1);
    compare_out("bp_first");
    @(posedge clk);
    sb_q.push_back(model(2'b10, 1'b1, 1'b0, 3'b100, 32'h0000_F0F0, 32'h0000_FF00));
    #1;
    in_valid = 1'b0;
    check_eq("b2b_out_valid", out_valid, 1'b1);
    compare_out("b2b_second");
    check_eq("b2b_lit", result, 32'h0000_0FF0);
    @(posedge clk); #1;

    // Reset in the third cycle of a 31-bit SLL aborts it silently.
    @(negedge clk);
    alu_op = 2'b10; op5 = 1'b1; funct7_5 = 1'b0; funct3 = 3'b001;
    src_a = 32'd1; src_b = 32'd31; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check_eq("abort_in_ready_rst", in_ready, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    check_eq("abort_outs", {out_valid, result, zero, negative, carry, overflow, alu_control},
             {1'b0, 32'd0, 4'b0000, 4'b0000});
    check_eq("abort_in_ready", in_ready, 1'b1);
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
    check_eq("abort_no_resp", 64'(seen), 64'd0);
    run_op(2'b10, 1'b1, 1'b0, 3'b001, 32'd1, 32'd31, 32, "post_rst_sll");
    check_eq("post_rst_sll_lit", result, 32'h8000_0000);

    // Randomised ops through the scoreboard.
    for (int n = 0; n < 24; n++) begin
      r_op  = 2'($urandom_range(0, 3));
      r_f3  = 3'($urandom_range(0, 7));
      r_o5  = 1'($urandom_range(0, 1));
      r_f75 = 1'($urandom_range(0, 1));
      r_a   = $urandom;
      r_b   = $urandom;
      e = model(r_op, r_o5, r_f75, r_f3, r_a, r_b);
      lat = 1;
      if ((e.ctrl == 4'd7 || e.ctrl == 4'd8 || e.ctrl == 4'd9) && r_b[4:0] != 5'd0)
        lat = 1 + int'(r_b[4:0]);
      run_op(r_op, r_o5, r_f75, r_f3, r_a, r_b, lat, $sformatf("rnd%0d", n));
    end

    check_eq("sb_drained", 64'(sb_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
